// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle control unit.
// Holds the FSM state enum, the ALU operation-class enum, the opcode/funct
// field values, and the ALU function codes (also used by the datapath ALU).
package mc_pkg;

  localparam int MC_OPW = 6;
  localparam int MC_FW  = 3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  // What the ALU is being asked to do in a given state.
  typedef enum logic [1:0] {AC_NONE, AC_ADD, AC_SUB, AC_FUNCT} aluclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NEG = 6'b100111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_NEG = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control-unit <-> datapath/memory bundle.
//   master (control unit): receives opcode, funct, zero, mem_ready;
//     drives alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
//     memwrite, regwrite, regdst, memtoreg, illegal.
//   slave (datapath/memory): the reverse directions.
interface mc_ctrl_if #(
  parameter int OPW = 6,
  parameter int FW  = 3
);
  logic [OPW-1:0] opcode;
  logic [OPW-1:0] funct;
  logic           zero;
  logic           mem_ready;
  logic [FW-1:0]  alucontrol;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [1:0]     pcsrc;
  logic           pcen;
  logic           iord;
  logic           irwrite;
  logic           memwrite;
  logic           regwrite;
  logic           regdst;
  logic           memtoreg;
  logic           illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
           memwrite, regwrite, regdst, memtoreg, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
           memwrite, regwrite, regdst, memtoreg, illegal
  );
endinterface

// File: rtl/mc_aludec.sv
// mc_aludec: combinational ALU function-code decode.
//   cls         in   operation class requested by the current state
//   funct       in   instr[5:0], only meaningful for AC_FUNCT
//   f           out  ALU function code
//   funct_legal out  funct is a supported R-type function (AC_FUNCT only)
module mc_aludec
  import mc_pkg::*;
#(
  parameter int OPW = MC_OPW,
  parameter int FW  = MC_FW
) (
  input  aluclass_t      cls,
  input  logic [OPW-1:0] funct,
  output logic [FW-1:0]  f,
  output logic           funct_legal
);

  always_comb begin
    f           = '0;
    funct_legal = 1'b0;
    case (cls)
      AC_ADD: f = ALU_ADD;
      AC_SUB: f = ALU_SUB;
      AC_FUNCT: begin
        funct_legal = 1'b1;
        case (funct)
          F_ADD:   f = ALU_ADD;
          F_SUB:   f = ALU_SUB;
          F_AND:   f = ALU_AND;
          F_OR:    f = ALU_OR;
          F_SLT:   f = ALU_SLT;
          F_NEG:   f = ALU_NEG;
          default: begin
            f           = ALU_AND;
            funct_legal = 1'b0;
          end
        endcase
      end
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control unit for a MIPS-subset datapath.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    mc_ctrl_if.master: IR fields, zero flag, mem_ready in;
//          ALU select, mux selects, write enables and illegal pulse out.
// Build option: MC_CTRL_BNE_EN adds bne (opcode 000101) as a branch.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 when mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEMADR   | compute load/store address
// MEMRD    | load read, wait for mem_ready
// MEMWB    | write load data to rt
// MEMWR    | store write, hold until mem_ready
// EXEC     | R-type ALU operation
// ALUWB    | write R-type result to rd
// BRANCH   | compare, conditionally load PC from ALUOut
// ADDIEX   | addi ALU operation
// ADDIWB   | write addi result to rt
// JUMP     | load PC with jump target
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int OPW = MC_OPW,
  parameter int FW  = MC_FW
) (
  input logic        clk,
  input logic        rst_n,
  mc_ctrl_if.master  bus
);

  state_t    state, state_nx;
  logic      is_sw, is_sw_nx;
  logic      illegal_q, illegal_nx;
  aluclass_t cls;
  logic      funct_legal;
  logic [FW-1:0] alu_f;
  logic      pcen_c, irwrite_c, memwrite_c, regwrite_c;
`ifdef MC_CTRL_BNE_EN
  logic      is_bne, is_bne_nx;
`endif

  mc_aludec #(.OPW(OPW), .FW(FW)) u_aludec (
    .cls         (cls),
    .funct       (bus.funct),
    .f           (alu_f),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      is_sw     <= 1'b0;
      illegal_q <= 1'b0;
`ifdef MC_CTRL_BNE_EN
      is_bne    <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      is_sw     <= is_sw_nx;
      illegal_q <= illegal_nx;
`ifdef MC_CTRL_BNE_EN
      is_bne    <= is_bne_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    is_sw_nx     = is_sw;
    illegal_nx   = 1'b0;
    cls          = AC_NONE;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.iord     = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    pcen_c       = 1'b0;
    irwrite_c    = 1'b0;
    memwrite_c   = 1'b0;
    regwrite_c   = 1'b0;
`ifdef MC_CTRL_BNE_EN
    is_bne_nx    = is_bne;
`endif
    case (state)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        cls         = AC_ADD;
        irwrite_c   = bus.mem_ready;
        pcen_c      = bus.mem_ready;
        if (bus.mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        cls         = AC_ADD;
        // Load vs store is remembered here so MEMADR need not look at the IR.
        is_sw_nx    = (bus.opcode == OP_SW);
`ifdef MC_CTRL_BNE_EN
        is_bne_nx   = (bus.opcode == OP_BNE);
`endif
        case (bus.opcode)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_EXEC;
          OP_BEQ:       state_nx = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_nx = S_BRANCH;
`endif
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JUMP;
          default: begin
            state_nx   = S_FETCH;
            illegal_nx = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        cls         = AC_ADD;
        state_nx    = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        if (bus.mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c   = 1'b1;
        bus.memtoreg = 1'b1;
        state_nx     = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord   = 1'b1;
        memwrite_c = 1'b1;
        if (bus.mem_ready) state_nx = S_FETCH;
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        cls         = AC_FUNCT;
        if (funct_legal) begin
          state_nx = S_ALUWB;
        end else begin
          state_nx   = S_FETCH;
          illegal_nx = 1'b1;
        end
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        bus.regdst = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        cls         = AC_SUB;
        bus.pcsrc   = 2'b01;
`ifdef MC_CTRL_BNE_EN
        pcen_c      = is_bne ? ~bus.zero : bus.zero;
`else
        pcen_c      = bus.zero;
`endif
        state_nx    = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        cls         = AC_ADD;
        state_nx    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_nx   = S_FETCH;
      end
      S_JUMP: begin
        bus.pcsrc = 2'b10;
        pcen_c    = 1'b1;
        state_nx  = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // FETCH enables follow mem_ready combinationally, so they must also be
  // masked directly by reset rather than relying on the state register.
  assign bus.pcen       = pcen_c & rst_n;
  assign bus.irwrite    = irwrite_c & rst_n;
  assign bus.memwrite   = memwrite_c & rst_n;
  assign bus.regwrite   = regwrite_c & rst_n;
  assign bus.alucontrol = alu_f;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic ill_next = 1'b0;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control word: {alu, srca, srcb, pcsrc, pcen, iord, irwrite, memwrite,
  //                regwrite, regdst, memtoreg, illegal}
  function automatic logic [15:0] w(input logic [2:0] alu, input logic srca,
                                    input logic [1:0] srcb, input logic [1:0] pcsrc,
                                    input logic pcen, input logic iord, input logic irw,
                                    input logic memw, input logic regw,
                                    input logic rdst, input logic m2r);
    return {alu, srca, srcb, pcsrc, pcen, iord, irw, memw, regw, rdst, m2r, 1'b0};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.alucontrol, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen, bus.iord,
            bus.irwrite, bus.memwrite, bus.regwrite, bus.regdst, bus.memtoreg,
            bus.illegal};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Supported R-type functions and their ALU codes.
  function automatic void fdec(input logic [5:0] fn, output logic [2:0] f,
                               output logic ok);
    ok = 1'b1;
    case (fn)
      6'b100000: f = 3'b010;
      6'b100010: f = 3'b110;
      6'b100100: f = 3'b000;
      6'b100101: f = 3'b001;
      6'b101010: f = 3'b111;
      6'b100111: f = 3'b100;
      default: begin f = 3'b000; ok = 1'b0; end
    endcase
  endfunction

  task automatic chk(input logic [15:0] got, input logic [15:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare the control word mid-cycle, advance.
  task automatic step(input logic mr, input logic z, input logic [15:0] e,
                      input logic raise, input string tag);
    bus.mem_ready = mr;
    bus.zero      = z;
    @(negedge clk);
    chk(obs(), e | {15'b0, ill_next}, tag);
    ill_next = raise;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fstall, input int mstall);
    logic [2:0] f;
    logic       fok;
    logic       bne_ok;
    bus.opcode = op;
    bus.funct  = fn;
`ifdef MC_CTRL_BNE_EN
    bne_ok = 1'b1;
`else
    bne_ok = 1'b0;
`endif
    repeat (fstall) step(1'b0, rb(), w(3'b010,0,2'b01,2'b00,0,0,0,0,0,0,0), 1'b0, "fetch_wait");
    step(1'b1, rb(), w(3'b010,0,2'b01,2'b00,1,0,1,0,0,0,0), 1'b0, "fetch");
    if (op == OP_LW || op == OP_SW) begin
      step(rb(), rb(), w(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0), 1'b0, "decode");
      step(rb(), rb(), w(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0), 1'b0, "memadr");
      if (op == OP_LW) begin
        repeat (mstall) step(1'b0, rb(), w(3'b000,0,2'b00,2'b00,0,1,0,0,0,0,0), 1'b0, "memrd_wait");
        step(1'b1, rb(), w(3'b000,0,2'b00,2'b00,0,1,0,0,0,0,0), 1'b0, "memrd");
        step(rb(), rb(), w(3'b000,0,2'b00,2'b00,0,0,0,0,1,0,1), 1'b0, "memwb");
      end else begin
        repeat (mstall) step(1'b0, rb(), w(3'b000,0,2'b00,2'b00,0,1,0,1,0,0,0), 1'b0, "memwr_wait");
        step(1'b1, rb(), w(3'b000,0,2'b00,2'b00,0,1,0,1,0,0,0), 1'b0, "memwr");
      end
    end else if (op == OP_RTYPE) begin
      fdec(fn, f, fok);
      step(rb(), rb(), w(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0), 1'b0, "decode");
      step(rb(), rb(), w(f,1,2'b00,2'b00,0,0,0,0,0,0,0), !fok, "exec");
      if (fok) step(rb(), rb(), w(3'b000,0,2'b00,2'b00,0,0,0,0,1,1,0), 1'b0, "aluwb");
    end else if (op == OP_BEQ || (op == OP_BNE && bne_ok)) begin
      step(rb(), rb(), w(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0), 1'b0, "decode");
      step(rb(), z, w(3'b110,1,2'b00,2'b01,(op == OP_BNE) ? !z : z,0,0,0,0,0,0), 1'b0, "branch");
    end else if (op == OP_ADDI) begin
      step(rb(), rb(), w(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0), 1'b0, "decode");
      step(rb(), rb(), w(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0), 1'b0, "addiex");
      step(rb(), rb(), w(3'b000,0,2'b00,2'b00,0,0,0,0,1,0,0), 1'b0, "addiwb");
    end else if (op == OP_J) begin
      step(rb(), rb(), w(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0), 1'b0, "decode");
      step(rb(), rb(), w(3'b000,0,2'b00,2'b10,1,0,0,0,0,0,0), 1'b0, "jump");
    end else begin
      step(rb(), rb(), w(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0), 1'b1, "decode_illegal");
    end
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] fns [8];
    logic [5:0] op;
    logic [5:0] fn;
    bus.opcode    = 6'b0;
    bus.funct     = 6'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Held in reset with mem_ready high: FETCH outputs, enables masked.
    repeat (2) @(posedge clk);
    #1;
    chk(obs(), w(3'b010,0,2'b01,2'b00,0,0,0,0,0,0,0), "reset_state");
    rst_n = 1'b1;

    run_instr(OP_RTYPE, F_ADD, 1'b0, 0, 0);
    run_instr(OP_LW, 6'b0, 1'b0, 0, 3);
    run_instr(OP_BEQ, 6'b0, 1'b1, 0, 0);
    run_instr(OP_BEQ, 6'b0, 1'b0, 1, 0);
    run_instr(6'b111111, 6'b0, 1'b0, 0, 0);
    run_instr(OP_RTYPE, 6'b000000, 1'b0, 0, 0);
    run_instr(OP_RTYPE, F_NEG, 1'b0, 0, 0);
    run_instr(OP_ADDI, 6'b0, 1'b0, 0, 0);
    run_instr(OP_J, 6'b0, 1'b0, 0, 0);
    run_instr(OP_SW, 6'b0, 1'b0, 2, 2);
    run_instr(OP_BNE, 6'b0, 1'b0, 0, 0);
    run_instr(OP_BNE, 6'b0, 1'b1, 0, 0);

    // Store interrupted by reset while waiting in MEMWR.
    bus.opcode = OP_SW;
    step(1'b1, 1'b0, w(3'b010,0,2'b01,2'b00,1,0,1,0,0,0,0), 1'b0, "rst_fetch");
    step(1'b0, 1'b0, w(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0), 1'b0, "rst_decode");
    step(1'b0, 1'b0, w(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0), 1'b0, "rst_memadr");
    bus.mem_ready = 1'b0;
    #2;
    chk(obs(), w(3'b000,0,2'b00,2'b00,0,1,0,1,0,0,0), "rst_in_memwr");
    rst_n = 1'b0;
    #1;
    chk(obs(), w(3'b010,0,2'b01,2'b00,0,0,0,0,0,0,0), "rst_async");
    bus.mem_ready = 1'b1;
    #1;
    chk(obs(), w(3'b010,0,2'b01,2'b00,0,0,0,0,0,0,0), "rst_masked");
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ill_next = 1'b0;
    run_instr(OP_RTYPE, F_SLT, 1'b0, 0, 0);

    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b111111};
    fns = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_NEG, 6'b000000, 6'b111000};
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom_range(0, 63));
      else fn = fns[$urandom_range(0, 7)];
      run_instr(op, fn, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    run_instr(OP_J, 6'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control unit: the producer side of the ALU operation-select interface.
- Sequences instruction fetch, decode, execute, memory access and writeback for a MIPS-subset datapath.
- Drives the 3-bit ALU function code (f) consumed by the datapath ALU and samples the ALU zero flag for branches.
- Sits between the instruction register/memory interface and the datapath muxes and enables.

Parameters:
- OPW, 6, opcode/funct field width.
- FW, 3, ALU function-code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- zero  in  1  ALU zero flag (s == 0).
- mem_ready  in  1  memory handshake; access completes in the cycle it is high.
- alucontrol  out  3  ALU function code.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm << 2.
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  instruction register load.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = memory data, 0 = ALUOut.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state = FETCH; illegal = 0. While rst_n = 0, all write enables (pcen, irwrite, memwrite, regwrite) are forced 0.
- ALU codes: AND 000, OR 001, ADD 010, SUB 110, NEG 100, SLT 111.
- Outputs: Moore-decoded from state, except pcen/irwrite in FETCH and the branch pcen, which are gated combinationally. Any output not listed for a state is 0.
- FETCH:
  - iord = 0, alusrca = 0, alusrcb = 01, alucontrol = 010, pcsrc = 00.
  - irwrite = pcen = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - alusrca = 0, alusrcb = 11, alucontrol = 010 (branch target into ALUOut).
  - Next state by opcode:
    - 100011 (lw) / 101011 (sw) -> MEMADR.
    - 000000 -> EXEC.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JUMP.
    - Any other opcode -> FETCH with illegal = 1 for one cycle.
- MEMADR: alusrca = 1, alusrcb = 10, alucontrol = 010. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord = 1. Waits for mem_ready, then -> MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0. -> FETCH.
- MEMWR: iord = 1, memwrite = 1. memwrite is held until mem_ready, then -> FETCH.
- EXEC:
  - alusrca = 1, alusrcb = 00.
  - funct decode: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, 100111 -> 100 (NEG).
  - Legal funct -> ALUWB. Unknown funct -> alucontrol = 000, illegal pulse, -> FETCH with no write.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0. -> FETCH.
- BRANCH:
  - alusrca = 1, alusrcb = 00, alucontrol = 110, pcsrc = 01.
  - pcen = zero, using the zero flag in the same cycle.
  - -> FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, alucontrol = 010. -> ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0. -> FETCH.
- JUMP: pcsrc = 10, pcen = 1. -> FETCH.
- Latency (instruction cycles with mem_ready always high):
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Asynchronous reset mid-instruction: immediate return to FETCH; no pending write completes.
- opcode/funct are sampled only in DECODE/EXEC (the IR is stable after FETCH).

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined:
  - Opcode 000101 (bne) in DECODE -> BRANCH.
  - Branch type is registered in DECODE.
  - In BRANCH, pcen = ~zero for bne and zero for beq.
- Undefined: 000101 is illegal (pulse, return to FETCH).

Decomposition:
- Shared package mc_pkg:
  - State enum (12 states).
  - Opcode and funct localparams.
  - ALU f-code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NEG, ALU_SLT); the same constants are reused by the ALU.
- One natural sub-module: mc_aludec, a combinational mapping from state class + funct to alucontrol + funct_legal.

Test Plan:
- Reset then add (opcode 000000, funct 100000), mem_ready = 1 -> states FETCH, DECODE, EXEC, ALUWB; alucontrol = 010 in EXEC; regwrite = 1, regdst = 1 in ALUWB; back to FETCH.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> iord = 1 held 4 cycles; then MEMWB with regwrite = 1, memtoreg = 1.
- beq (000100): zero = 1 -> pcen = 1, pcsrc = 01, alucontrol = 110 in BRANCH. zero = 0 -> pcen = 0.
- Opcode 111111, then R-type with funct 000000 -> illegal pulses exactly one cycle each; regwrite and memwrite never assert.
- sw (101011), rst_n dropped in MEMWR -> memwrite = 0 immediately; state FETCH after release.
- With MC_CTRL_BNE_EN, bne (000101) and zero = 0 -> pcen = 1. Without the macro -> illegal = 1.
